// File: rtl/vdma_pkg.sv
// Shared types and helpers for the VDMA burst sequencer.
package vdma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BASE,
        ST_SETTLE,
        ST_REQ,
        ST_WAIT,
        ST_PULSE
    } state_t;

    localparam int AXI_LEN_W = 8;

    // AXI len (beats-1) of the next burst given the beats still owed on the line.
    function automatic logic [AXI_LEN_W-1:0] burst_len_f(input int unsigned beats_left,
                                                          input int unsigned blen);
        if (beats_left > blen)
            return AXI_LEN_W'(blen - 1);
        else
            return AXI_LEN_W'(beats_left - 1);
    endfunction

endpackage

// File: rtl/vdma_settle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module vdma_settle_timer #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/vdma_burst_sequencer.sv
// Splits each video line into AXI bursts plus a tail, sequences lines until the
// frame ends, and pulses the address generator's control inputs along the way.
module vdma_burst_sequencer
    import vdma_pkg::*;
#(
    parameter int ASIZE       = 29,
    parameter int LSIZE       = 16,
    parameter int FSIZE       = 12,
    parameter int BURST_LEN   = 64,
    parameter int ADDR_SETTLE = 3
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [LSIZE-1:0]     line_beats,
    input  logic [FSIZE-1:0]     frame_lines,
    input  logic [ASIZE-1:0]     addr_in,
    output logic                 new_base,
    output logic                 burst_done,
    output logic                 tail_done,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [ASIZE-1:0]     cmd_addr,
    output logic [AXI_LEN_W-1:0] cmd_len,
    input  logic                 burst_resp,
    output logic                 busy,
    output logic                 frame_done,
    output logic [FSIZE-1:0]     line_cnt
);

    localparam int TW = (ADDR_SETTLE > 1) ? $clog2(ADDR_SETTLE) : 1;

    state_t           state, state_nxt;
    logic [LSIZE-1:0] lb, beats_left;
    logic [FSIZE-1:0] fl;
    logic             is_tail, req_armed, stop_pend;
    logic             accept, hs, last_line, settle_load, settle_done;

    assign accept    = start && (line_beats != '0) && (frame_lines != '0);
    assign hs        = cmd_valid && cmd_ready;
    assign last_line = (line_cnt == fl - FSIZE'(1));
    assign cmd_valid = (state == ST_REQ) && req_armed;
    assign busy      = (state != ST_IDLE);

    vdma_settle_timer #(.W(TW)) u_settle (
        .clock    (clock),
        .rst      (rst),
        .load     (settle_load),
        .load_val (TW'(ADDR_SETTLE - 1)),
        .done     (settle_done)
    );

    always_ff @(posedge clock) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        new_base    = 1'b0;
        burst_done  = 1'b0;
        tail_done   = 1'b0;
        frame_done  = 1'b0;
        settle_load = 1'b0;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_BASE;
            ST_BASE: begin
                new_base    = 1'b1;
                settle_load = 1'b1;
                state_nxt   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (stop || stop_pend) state_nxt = ST_IDLE;
                else if (settle_done)  state_nxt = ST_REQ;
            end
            ST_REQ:    if (hs) state_nxt = ST_WAIT;
            ST_WAIT:   if (burst_resp) state_nxt = ST_PULSE;
            ST_PULSE: begin
                settle_load = 1'b1;
                tail_done   = is_tail;
                burst_done  = !is_tail;
                if (stop_pend) begin
                    state_nxt = ST_IDLE;
                end else if (is_tail && last_line) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // A stop seen mid-burst is remembered so the burst can finish and pulse first.
    always_ff @(posedge clock) begin
        if (rst) begin
            lb         <= '0;
            fl         <= '0;
            beats_left <= '0;
            line_cnt   <= '0;
            cmd_addr   <= '0;
            cmd_len    <= '0;
            is_tail    <= 1'b0;
            req_armed  <= 1'b0;
            stop_pend  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lb         <= line_beats;
                        fl         <= frame_lines;
                        beats_left <= line_beats;
                        line_cnt   <= '0;
                        req_armed  <= 1'b0;
                        stop_pend  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (!req_armed) begin
                        cmd_addr  <= addr_in;
                        cmd_len   <= burst_len_f(32'(beats_left), BURST_LEN);
                        is_tail   <= (32'(beats_left) <= BURST_LEN);
                        req_armed <= 1'b1;
                    end else if (hs) begin
                        req_armed <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (burst_resp)
                        beats_left <= beats_left - (LSIZE'(cmd_len) + LSIZE'(1));
                end
                ST_PULSE: begin
                    if (is_tail && !last_line) begin
                        line_cnt   <= line_cnt + FSIZE'(1);
                        beats_left <= lb;
                    end
                end
                default: ;
            endcase
            if (stop && (state == ST_BASE || state == ST_REQ ||
                         state == ST_WAIT || state == ST_PULSE))
                stop_pend <= 1'b1;
        end
    end

endmodule

// File: doc/vdma_burst_sequencer.md
Name: vdma_burst_sequencer

Overview:
- Drives the address-generator control interface (new_base, burst_done, tail_done) and issues burst commands to the AXI AR/AW channel wrapper, using the current address taken from the generator.
- Splits each video line into full bursts plus one tail burst, and sequences lines until the frame completes.
- One instance sits on the write side of the VDMA and one on the read side.

Parameters:
- ASIZE, 29, address width; matches the address generator.
- LSIZE, 16, width of the line-length field in beats.
- FSIZE, 12, width of the lines-per-frame field.
- BURST_LEN, 64, beats per full burst; 1..256.
- ADDR_SETTLE, 3, idle cycles after any control pulse before addr_in is sampled. Covers the generator's edge-detect plus register latency.

Ports:
- clock, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, frame start pulse.
- stop, input, 1, graceful stop request pulse.
- line_beats, input, LSIZE, beats per line; sampled on accepted start.
- frame_lines, input, FSIZE, lines per frame; sampled on accepted start.
- addr_in, input, ASIZE, current address from the generator.
- new_base, output, 1, one-cycle pulse that reloads the generator base.
- burst_done, output, 1, one-cycle pulse after a full burst completes.
- tail_done, output, 1, one-cycle pulse after the last burst of a line completes.
- cmd_valid, output, 1, burst command valid.
- cmd_ready, input, 1, burst command accepted.
- cmd_addr, output, ASIZE, burst start address.
- cmd_len, output, 8, AXI len field (beats-1).
- burst_resp, input, 1, one-cycle pulse when the issued burst has fully completed (last data beat or B response).
- busy, output, 1, high from accepted start until return to IDLE.
- frame_done, output, 1, one-cycle pulse when the last tail of the frame completes.
- line_cnt, output, FSIZE, index of the line currently being processed.

Behaviour:
- Reset: synchronous; all state is cleared on the clock edge with rst=1.
  - All outputs reset to 0; the FSM resets to IDLE.
  - rst mid-frame abandons everything, including an outstanding burst; no pulses are emitted.
- States: IDLE, BASE, SETTLE, REQ, WAIT, PULSE.
- IDLE:
  - Accept start only if line_beats!=0 and frame_lines!=0. Otherwise start is ignored, with no pulse.
  - On accept: latch lb=line_beats, fl=frame_lines; beats_left=lb, line_cnt=0, busy=1; go to BASE.
- BASE: new_base=1 for one cycle; go to SETTLE.
- SETTLE: count ADDR_SETTLE cycles, then go to REQ.
- REQ:
  - Entry cycle: cmd_addr=addr_in registered; cmd_len = (beats_left>BURST_LEN) ? BURST_LEN-1 : beats_left-1; is_tail = (beats_left<=BURST_LEN).
  - cmd_valid asserts the cycle after entry.
  - cmd_addr, cmd_len and cmd_valid are held stable until cmd_ready; the handshake completes on cmd_valid&&cmd_ready. Then cmd_valid=0; go to WAIT.
- WAIT:
  - On burst_resp: beats_left -= cmd_len+1; go to PULSE.
  - A burst_resp seen in any other state is ignored.
- PULSE, one cycle: is_tail ? tail_done=1 : burst_done=1.
  - Not tail: go to SETTLE.
  - Tail, not last line: line_cnt++, beats_left=lb; go to SETTLE.
  - Tail, last line (line_cnt==fl-1): frame_done=1 in the same cycle, busy=0 next cycle; go to IDLE.
- Exact multiple: when lb is a multiple of BURST_LEN, the final burst of a line is a full-length burst but is flagged tail (tail_done, not burst_done).
- Pulse spacing: at most one of new_base/burst_done/tail_done is high in any cycle. Consecutive pulses are at least ADDR_SETTLE+2 cycles apart, so the generator's edge detectors always see a distinct rising edge.
- stop:
  - In SETTLE: go to IDLE immediately with no pulse.
  - In REQ or WAIT: the current burst is completed and its PULSE is emitted, then go to IDLE.
  - frame_done is not asserted on a stopped frame.
  - stop in IDLE is a no-op.
- start while busy is ignored; start and stop in the same cycle in IDLE: start wins.
- Arithmetic: beats_left is LSIZE bits and never underflows, because cmd_len+1 <= beats_left by construction. Comparisons are unsigned.

Decomposition:
- Shared package vdma_pkg holds:
  - the state enum;
  - the AXI_LEN_W=8 constant;
  - a function computing burst length from beats_left and BURST_LEN.
- One natural sub-module: vdma_settle_timer, a loadable down-counter with a done flag, reused for ADDR_SETTLE.

Test Plan:
- BURST_LEN=64, line_beats=200, frame_lines=2, cmd_ready tied high, burst_resp 5 cycles after handshake:
  - per line: cmd_len 63,63,63,7; pulses burst_done×3 then tail_done;
  - frame_done once at the end; new_base exactly once.
- line_beats=128: cmd_len 63,63; one burst_done then one tail_done per line (exact-multiple case).
- cmd_ready held low for 10 cycles: cmd_valid, cmd_addr and cmd_len stay constant; no pulse until burst_resp follows the handshake.
- Model the generator (addr += 0x1000 on each burst_done rising edge): each cmd_addr equals the updated addr_in, proving ADDR_SETTLE=3 suffices.
- stop asserted while in WAIT on burst 2 of line 0: that burst_done is emitted, busy drops, no frame_done, no further cmd_valid.
- rst pulsed while in REQ: next cycle cmd_valid=0, busy=0, all pulses 0; a subsequent start with line_beats=0 is ignored.
